// File: rtl/pipeline_run_monitor_pkg.sv
// Shared definitions for the pipeline run monitor.
//  - FSM state encoding (IDLE/RUN/PASS/FAIL)
//  - fail_code values reported on the monitor outputs
//  - small helper to classify terminal states
package pipe_mon_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_PASS = 2'd2;
   localparam logic [1:0] ST_FAIL = 2'd3;

   localparam logic [1:0] FAIL_NONE     = 2'b00;
   localparam logic [1:0] FAIL_TIMEOUT  = 2'b01;
   localparam logic [1:0] FAIL_DEADLOCK = 2'b10;

   typedef logic [1:0] mon_state_t;

   function automatic logic is_terminal(input mon_state_t st);
      return (st == ST_PASS) || (st == ST_FAIL);
   endfunction

endpackage

// File: rtl/pipeline_run_monitor_if.sv
// Signal bundle between the observed pipeline (master side) and the run
// monitor (slave side).
//
// Sampling contract: there is no valid/ready handshake. Every input is a
// level sampled on each rising clk edge while the monitor is in RUN with
// run_en=1; outputs are registered except hist_pc, which is a combinational
// read of the history ring addressed by hist_idx.
//
//  master: drives run_en, pc, stallf, stalld, flushe, regwrite_w,
//          writereg_w, hist_idx; observes everything else
//  slave : the monitor itself
import pipe_mon_pkg::*;

interface pipeline_run_monitor_if #(
   parameter int XLEN    = 32,
   parameter int REG_AW  = 5,
   parameter int HIST_AW = 3,
   parameter int CNT_W   = 32
);
   logic              run_en;
   logic [XLEN-1:0]   pc;
   logic              stallf;
   logic              stalld;
   logic              flushe;
   logic              regwrite_w;
   logic [REG_AW-1:0] writereg_w;
   logic [HIST_AW-1:0] hist_idx;
   logic [XLEN-1:0]   hist_pc;
   logic              done;
   logic              pass;
   logic [1:0]        fail_code;
   logic [CNT_W-1:0]  cycle_cnt;
   logic [CNT_W-1:0]  stall_cnt;
   logic [CNT_W-1:0]  flush_cnt;
   logic [CNT_W-1:0]  retire_cnt;
   mon_state_t        dbg_state;   // FSM state, for checkers and debug

   modport master (
      output run_en, pc, stallf, stalld, flushe, regwrite_w, writereg_w, hist_idx,
      input  hist_pc, done, pass, fail_code, cycle_cnt, stall_cnt, flush_cnt,
             retire_cnt, dbg_state
   );

   modport slave (
      input  run_en, pc, stallf, stalld, flushe, regwrite_w, writereg_w, hist_idx,
      output hist_pc, done, pass, fail_code, cycle_cnt, stall_cnt, flush_cnt,
             retire_cnt, dbg_state
   );
endinterface

// File: rtl/pipeline_run_monitor_hist.sv
// pc_history_ring: circular buffer of recently fetched PCs.
//  clk, rst    : clock, asynchronous active-high reset (clears entries and pointer)
//  we_i        : write wdata_i at the write pointer, then advance it
//  wdata_i     : PC to record
//  rd_idx_i    : read index, 0 = newest entry
//  rd_data_o   : entry at rd_idx_i (combinational); unwritten slots read 0
module pc_history_ring #(
   parameter int XLEN       = 32,
   parameter int HIST_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          we_i,
   input  logic [XLEN-1:0]               wdata_i,
   input  logic [$clog2(HIST_DEPTH)-1:0] rd_idx_i,
   output logic [XLEN-1:0]               rd_data_o
);
   localparam int AW = $clog2(HIST_DEPTH);

   logic [XLEN-1:0] mem_q [HIST_DEPTH];
   logic [AW-1:0]   wp_q;
   logic [AW-1:0]   rd_ptr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < HIST_DEPTH; i++) mem_q[i] <= '0;
         wp_q <= '0;
      end else if (we_i) begin
         mem_q[wp_q] <= wdata_i;
         wp_q        <= wp_q + AW'(1);
      end
   end

   // Depth is a power of two, so the pointer arithmetic wraps modulo depth.
   assign rd_ptr    = wp_q - AW'(1) - rd_idx_i;
   assign rd_data_o = mem_q[rd_ptr];

endmodule

// File: rtl/pipeline_run_monitor.sv
// pipeline_run_monitor: run monitor for the 5-stage MIPS pipeline.
// Counts RUN cycles, stalls, flushes and retirements, keeps a fetch-PC
// history ring, and ends in PASS (fetch PC reached DONE_PC) or FAIL
// (deadlock: STALL_LIMIT consecutive stalled cycles; or timeout).
//  clk, reset : clock, asynchronous active-high reset
//  mon        : slave side of pipeline_run_monitor_if (inputs from the
//               pipeline, counters/status/history outputs, debug state)
import pipe_mon_pkg::*;

module pipeline_run_monitor #(
   parameter int              XLEN           = 32,
   parameter int              REG_AW         = 5,
   parameter logic [XLEN-1:0] DONE_PC        = 32'h5c,
   parameter int              TIMEOUT_CYCLES = 1000,
   parameter int              STALL_LIMIT    = 16,
   parameter int              CNT_W          = 32,
   parameter int              HIST_DEPTH     = 8
) (
   input logic                   clk,
   input logic                   reset,
   pipeline_run_monitor_if.slave mon
);
   localparam int CONS_W = $clog2(STALL_LIMIT + 1);
   localparam logic [CNT_W-1:0]  CNT_ONE      = CNT_W'(1);
   localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CONS_W-1:0] STALL_LAST   = CONS_W'(STALL_LIMIT - 1);
   localparam logic [CONS_W-1:0] STALL_MAX    = CONS_W'(STALL_LIMIT);

   mon_state_t        state_q, state_d;
   logic [1:0]        fail_q, fail_d;
   logic [CNT_W-1:0]  cycle_q, cycle_d;
   logic [CNT_W-1:0]  stall_q, stall_d;
   logic [CNT_W-1:0]  flush_q, flush_d;
   logic [CNT_W-1:0]  retire_q, retire_d;
   logic [CONS_W-1:0] consec_q, consec_d;
   logic [XLEN-1:0]   last_pc_q, last_pc_d;
   logic              last_vld_q, last_vld_d;

   logic count_en;
   logic stalled;
   logic retire;
   logic hist_we;

   assign count_en = (state_q == ST_RUN) && mon.run_en;
   assign stalled  = mon.stallf | mon.stalld;
   assign retire   = mon.regwrite_w && (mon.writereg_w != '0);

   // Record a PC only when fetch advanced to a new address. last_vld_q lets
   // the very first PC of a run be captured even if it equals the reset value.
   assign hist_we = count_en && !mon.stallf && (!last_vld_q || (mon.pc != last_pc_q));

   always_comb begin
      state_d    = state_q;
      fail_d     = fail_q;
      cycle_d    = cycle_q;
      stall_d    = stall_q;
      flush_d    = flush_q;
      retire_d   = retire_q;
      consec_d   = consec_q;
      last_pc_d  = last_pc_q;
      last_vld_d = last_vld_q;

      if (state_q == ST_IDLE) begin
         if (mon.run_en) state_d = ST_RUN;
      end else if (count_en) begin
         // Counters saturate at all-ones.
         if (~&cycle_q) cycle_d = cycle_q + CNT_ONE;
         if (stalled && ~&stall_q) stall_d = stall_q + CNT_ONE;
         if (mon.flushe && ~&flush_q) flush_d = flush_q + CNT_ONE;
         if (retire && ~&retire_q) retire_d = retire_q + CNT_ONE;

         if (!stalled)                   consec_d = '0;
         else if (consec_q != STALL_MAX) consec_d = consec_q + CONS_W'(1);

         if (hist_we) begin
            last_pc_d  = mon.pc;
            last_vld_d = 1'b1;
         end

         // Terminal priority: PASS over deadlock over timeout.
         if (mon.pc == DONE_PC) begin
            state_d = ST_PASS;
         end else if (stalled && (consec_q == STALL_LAST)) begin
            state_d = ST_FAIL;
            fail_d  = FAIL_DEADLOCK;
         end else if (cycle_q == TIMEOUT_LAST) begin
            state_d = ST_FAIL;
            fail_d  = FAIL_TIMEOUT;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         fail_q     <= FAIL_NONE;
         cycle_q    <= '0;
         stall_q    <= '0;
         flush_q    <= '0;
         retire_q   <= '0;
         consec_q   <= '0;
         last_pc_q  <= '0;
         last_vld_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         fail_q     <= fail_d;
         cycle_q    <= cycle_d;
         stall_q    <= stall_d;
         flush_q    <= flush_d;
         retire_q   <= retire_d;
         consec_q   <= consec_d;
         last_pc_q  <= last_pc_d;
         last_vld_q <= last_vld_d;
      end
   end

   pc_history_ring #(
      .XLEN       (XLEN),
      .HIST_DEPTH (HIST_DEPTH)
   ) u_hist (
      .clk       (clk),
      .rst       (reset),
      .we_i      (hist_we),
      .wdata_i   (mon.pc),
      .rd_idx_i  (mon.hist_idx),
      .rd_data_o (mon.hist_pc)
   );

   assign mon.done       = is_terminal(state_q);
   assign mon.pass       = (state_q == ST_PASS);
   assign mon.fail_code  = fail_q;
   assign mon.cycle_cnt  = cycle_q;
   assign mon.stall_cnt  = stall_q;
   assign mon.flush_cnt  = flush_q;
   assign mon.retire_cnt = retire_q;
   assign mon.dbg_state  = state_q;

endmodule

// File: tb/tb_pipeline_run_monitor.sv
// Directed bench for pipeline_run_monitor. TIMEOUT_CYCLES is set to 30 so the
// 24-cycle PASS program completes before timeout while the timeout scenario
// stays short.
import pipe_mon_pkg::*;

module tb_pipeline_run_monitor;
   localparam int XLEN = 32, REG_AW = 5, HIST_DEPTH = 8, HIST_AW = 3, CNT_W = 32;
   localparam int STALL_LIMIT = 16, TIMEOUT = 30;

   logic clk;
   logic reset;

   pipeline_run_monitor_if #(.XLEN(XLEN), .REG_AW(REG_AW), .HIST_AW(HIST_AW), .CNT_W(CNT_W)) mon_if ();

   pipeline_run_monitor #(
      .XLEN(XLEN), .REG_AW(REG_AW), .DONE_PC(32'h5c), .TIMEOUT_CYCLES(TIMEOUT),
      .STALL_LIMIT(STALL_LIMIT), .CNT_W(CNT_W), .HIST_DEPTH(HIST_DEPTH)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .mon   (mon_if.slave)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b1;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish, observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- scoreboard ----------------
   logic [31:0] exp_q[$];
   int checks   = 0;
   int failures = 0;
   int m_cycle, m_stall, m_flush, m_retire;

   task automatic expect_v(input logic [31:0] v);
      exp_q.push_back(v);
   endtask

   task automatic check(input string tag, input logic [31:0] obs);
      logic [31:0] e;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $error("FAIL %s: observed=%h with no expected value queued", tag, obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, e);
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic run, input logic [31:0] pc, input logic sf, input logic sd,
                        input logic fl, input logic rw, input logic [4:0] wr);
      mon_if.run_en     = run;
      mon_if.pc         = pc;
      mon_if.stallf     = sf;
      mon_if.stalld     = sd;
      mon_if.flushe     = fl;
      mon_if.regwrite_w = rw;
      mon_if.writereg_w = wr;
   endtask

   // One counted RUN edge; the model tracks what the counters must become.
   task automatic run_step(input logic [31:0] pc, input logic sf, input logic sd,
                           input logic fl, input logic rw, input logic [4:0] wr);
      drive(1'b1, pc, sf, sd, fl, rw, wr);
      step();
      m_cycle++;
      if (sf || sd) m_stall++;
      if (fl) m_flush++;
      if (rw && wr != 5'd0) m_retire++;
   endtask

   task automatic do_reset();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
      mon_if.hist_idx = '0;
      reset = 1'b1;
      #2;
      reset = 1'b0;
      m_cycle = 0; m_stall = 0; m_flush = 0; m_retire = 0;
   endtask

   // IDLE -> RUN transition edge; nothing is counted on it.
   task automatic start_run();
      drive(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
      step();
   endtask

   task automatic check_counters(input string tag);
      expect_v(32'(m_cycle));  check({tag, "_cycle"},  mon_if.cycle_cnt);
      expect_v(32'(m_stall));  check({tag, "_stall"},  mon_if.stall_cnt);
      expect_v(32'(m_flush));  check({tag, "_flush"},  mon_if.flush_cnt);
      expect_v(32'(m_retire)); check({tag, "_retire"}, mon_if.retire_cnt);
   endtask

   task automatic check_status(input string tag, input logic d, input logic p, input logic [1:0] fc);
      expect_v({31'd0, d});  check({tag, "_done"}, {31'd0, mon_if.done});
      expect_v({31'd0, p});  check({tag, "_pass"}, {31'd0, mon_if.pass});
      expect_v({30'd0, fc}); check({tag, "_fail_code"}, {30'd0, mon_if.fail_code});
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      reset = 1'b1;
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
      mon_if.hist_idx = '0;
      m_cycle = 0; m_stall = 0; m_flush = 0; m_retire = 0;

      // 1: reset state, then straight-line program to DONE_PC
      #24;
      check_status("rst", 1'b0, 1'b0, FAIL_NONE);
      check_counters("rst");
      expect_v(32'h0); check("rst_hist", mon_if.hist_pc);
      expect_v({30'd0, ST_IDLE}); check("rst_state", {30'd0, mon_if.dbg_state});
      #1 reset = 1'b0;
      start_run();
      expect_v({30'd0, ST_RUN}); check("t1_state_run", {30'd0, mon_if.dbg_state});
      for (int i = 0; i < 24; i++) begin
         run_step(32'(i * 4), 1'b0, 1'b0, (i % 5) == 0, (i % 3) != 0, 5'(i % 4));
         if (i == 22) begin
            expect_v(32'd0); check("t1_not_done_early", {31'd0, mon_if.done});
         end
      end
      check_status("t1", 1'b1, 1'b1, FAIL_NONE);
      expect_v(32'd24); check("t1_cycle24", mon_if.cycle_cnt);
      check_counters("t1");
      // Terminal: further activity ignored, counters frozen.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h40, 1'b1, 1'b1, 1'b1, 1'b1, 5'd7);
         step();
      end
      check_status("t1_frozen", 1'b1, 1'b1, FAIL_NONE);
      check_counters("t1_frozen");

      // 2: deadlock after 16 consecutive stalled cycles
      do_reset();
      start_run();
      for (int i = 0; i < STALL_LIMIT - 1; i++) run_step(32'h10, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
      expect_v(32'd0); check("t2_not_done_15", {31'd0, mon_if.done});
      run_step(32'h10, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
      check_status("t2", 1'b1, 1'b0, FAIL_DEADLOCK);
      expect_v(32'd16); check("t2_stall16", mon_if.stall_cnt);
      check_counters("t2");

      // 3: timeout, pc looping 0..0x20
      do_reset();
      start_run();
      for (int i = 0; i < TIMEOUT - 1; i++) run_step(32'((i % 9) * 4), 1'b0, 1'b0, 1'b0, 1'b1, 5'd3);
      expect_v(32'd0); check("t3_not_done", {31'd0, mon_if.done});
      run_step(32'((29 % 9) * 4), 1'b0, 1'b0, 1'b0, 1'b1, 5'd3);
      check_status("t3", 1'b1, 1'b0, FAIL_TIMEOUT);
      expect_v(32'(TIMEOUT)); check("t3_cycle", mon_if.cycle_cnt);
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h4, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3);
         step();
      end
      check_counters("t3_frozen");

      // 4: DONE_PC on the same edge as the deadlock stall -> PASS wins
      do_reset();
      start_run();
      for (int i = 0; i < STALL_LIMIT - 1; i++) run_step(32'h10, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
      run_step(32'h5c, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
      check_status("t4", 1'b1, 1'b1, FAIL_NONE);
      expect_v(32'd16); check("t4_stall16", mon_if.stall_cnt);

      // 5: history ring, stallf and repeated PCs add no entry
      do_reset();
      start_run();
      for (int i = 0; i < 10; i++) begin
         run_step(32'(i * 4), 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
         if (i == 4) begin
            run_step(32'h200, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
            run_step(32'(i * 4), 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
         end
      end
      for (int k = 0; k < HIST_DEPTH; k++) begin
         mon_if.hist_idx = HIST_AW'(k);
         #1;
         expect_v(32'h24 - 32'(k * 4));
         check($sformatf("t5_hist%0d", k), mon_if.hist_pc);
      end
      mon_if.hist_idx = '0;
      expect_v(32'd0); check("t5_not_done", {31'd0, mon_if.done});

      // 6: asynchronous reset mid-run, then pause with run_en=0
      do_reset();
      start_run();
      for (int i = 0; i < 5; i++) run_step(32'(i * 4), i[0], 1'b0, 1'b1, 1'b1, 5'd1);
      reset = 1'b1;
      #1;
      m_cycle = 0; m_stall = 0; m_flush = 0; m_retire = 0;
      check_status("t6_async", 1'b0, 1'b0, FAIL_NONE);
      check_counters("t6_async");
      expect_v(32'h0); check("t6_async_hist", mon_if.hist_pc);
      expect_v({30'd0, ST_IDLE}); check("t6_async_state", {30'd0, mon_if.dbg_state});
      reset = 1'b0;
      start_run();
      run_step(32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd2);
      run_step(32'h4, 1'b0, 1'b0, 1'b0, 1'b1, 5'd2);
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 32'h5c, 1'b1, 1'b1, 1'b1, 1'b1, 5'd2);
         step();
      end
      expect_v(32'd2); check("t6_pause_cycle", mon_if.cycle_cnt);
      check_counters("t6_pause");
      check_status("t6_pause", 1'b0, 1'b0, FAIL_NONE);
      run_step(32'h8, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
      expect_v(32'd3); check("t6_resume_cycle", mon_if.cycle_cnt);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
